// File: rtl/ready_valid_slave_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : ready_valid_slave_fifo                                 |
// | Description : Receiving end of an 8-bit ready/valid link. Buffers    |
// |               accepted bytes in a first-word-fall-through FIFO,      |
// |               presents them on a second ready/valid port, counts     |
// |               accepted transfers and flags master protocol errors.   |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module ready_valid_slave_fifo #(
  parameter int DEPTH = 4,   // FIFO entries, power of two in 2..16
  parameter int CNT_W = 16   // transfer counter width
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 data,
  input  logic                       master_valid,
  output logic                       slave_ready,
  input  logic                       stall_en,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_W-1:0]           xfer_count,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       proto_err
);

  localparam int                 PTR_W    = $clog2(DEPTH);
  localparam int                 LVL_W    = PTR_W + 1;
  localparam logic [LVL_W-1:0]   FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]   LVL_ONE  = LVL_W'(1);

  // Storage is never reset; only the pointers and level define validity.
  logic [7:0]       mem_q [DEPTH];

  logic             rst_n_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             pend_q,   pend_d;
  logic [7:0]       pdata_q,  pdata_d;
  logic             err_q,    err_d;

  logic             push;
  logic             pop;
  logic             ready_w;
  logic             valid_w;

  // Handshake decode and next-state computation for every register.
  always_comb begin
    // Ready depends only on registered state plus reset/stall inputs, never
    // on out_ready or master_valid, so a pop frees space one cycle later.
    ready_w  = rst_n && rst_n_q && !stall_en && (level_q != FULL_LVL);
    valid_w  = (level_q != '0);
    push     = master_valid && ready_w;
    pop      = valid_w && out_ready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;   // power-of-two depth wraps naturally
      cnt_d    = cnt_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase

    // A byte offered but not taken must stay put with valid held high.
    if (pend_q && (!master_valid || (data != pdata_q))) begin
      err_d = 1'b1;
    end
    pend_d  = master_valid && !ready_w;
    pdata_d = data;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    rst_n_q <= rst_n;
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      pdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pdata_q  <= pdata_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage write; push is already blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  // Output drive; out_data reads zero whenever the FIFO is empty.
  always_comb begin
    slave_ready = ready_w;
    out_valid   = valid_w;
    out_data    = valid_w ? mem_q[rd_ptr_q] : 8'h00;
    xfer_count  = cnt_q;
    level       = level_q;
    proto_err   = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ready_valid_slave_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_ready_valid_slave_fifo                              |
// | Description : Self-checking bench; queue-based reference model.      |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_ready_valid_slave_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       data;
  logic             master_valid;
  logic             slave_ready;
  logic             stall_en;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] xfer_count;
  logic [LVL_W-1:0] level;
  logic             proto_err;

  ready_valid_slave_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data         (data),
    .master_valid (master_valid),
    .slave_ready  (slave_ready),
    .stall_en     (stall_en),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .xfer_count   (xfer_count),
    .level        (level),
    .proto_err    (proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] mq[$];
  int         m_cnt  = 0;
  bit         m_rstq = 0;
  bit         m_err  = 0;
  bit         m_pend = 0;
  logic [7:0] m_pdata = 8'h00;
  bit         last_push = 0;
  bit         last_pop  = 0;
  logic [7:0] popped[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check outputs against the model mid-cycle, then advance.
  task automatic cycle();
    bit         exp_ready;
    bit         exp_valid;
    logic [7:0] exp_data;
    @(negedge clk);
    exp_ready = rst_n && m_rstq && !stall_en && (mq.size() != DEPTH);
    exp_valid = (mq.size() != 0);
    exp_data  = exp_valid ? mq[0] : 8'h00;
    chk("slave_ready", 32'(slave_ready), 32'(exp_ready));
    chk("out_valid",   32'(out_valid),   32'(exp_valid));
    chk("out_data",    32'(out_data),    32'(exp_data));
    chk("level",       32'(level),       32'(mq.size()));
    chk("xfer_count",  32'(xfer_count),  32'(m_cnt));
    chk("proto_err",   32'(proto_err),   32'(m_err));
    last_push = master_valid && exp_ready;
    last_pop  = rst_n && exp_valid && out_ready;
    if (last_pop) popped.push_back(out_data);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0; m_err = 0; m_pend = 0; m_pdata = 8'h00; m_rstq = 0;
    end else begin
      if (m_pend && (!master_valid || data != m_pdata)) m_err = 1;
      m_pend  = master_valid && !exp_ready;
      m_pdata = data;
      if (last_pop) void'(mq.pop_front());
      if (last_push) mq.push_back(data);
      m_cnt  = (m_cnt + int'(last_push)) % (1 << CNT_W);
      m_rstq = 1;
    end
    #1;
  endtask

  // Offer one byte and hold it until accepted (bounded).
  task automatic send(input logic [7:0] b);
    master_valid = 1'b1;
    data = b;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (last_push) begin
        master_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 32'(last_push), 32'd1);
    master_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    master_valid = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; data = 8'h00; master_valid = 1'b0; stall_en = 1'b0; out_ready = 1'b0;
    #1;

    // 1: back-to-back stream through an always-ready consumer
    do_reset(2);
    chk("t1_reset_level", 32'(level), 32'd0);
    chk("t1_reset_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(8'h11); send(8'h22); send(8'h33);
    chk("t1_count", 32'(xfer_count), 32'd3);
    cycle();
    chk("t1_err", 32'(proto_err), 32'd0);

    // 2: fill to full, single pop, late ready return
    do_reset(1);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    master_valid = 1'b1; data = 8'hA4;
    repeat (3) cycle();
    chk("t2_full_level", 32'(level), 32'd4);
    chk("t2_full_ready", 32'(slave_ready), 32'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("t2_after_pop_ready", 32'(slave_ready), 32'd1);
    cycle();
    chk("t2_a4_taken", 32'(last_push), 32'd1);
    master_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) cycle();

    // 3: stream with stall toggling every two cycles
    do_reset(1);
    out_ready = 1'b1;
    popped.delete();
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      master_valid = 1'b1;
      data = 8'hC0 + 8'(i);
      for (int k = 0; k < 20; k++) begin
        stall_en = ((cyc / 2) % 2) == 1;
        cycle();
        cyc++;
        if (last_push) break;
      end
      chk("t3_accept", 32'(last_push), 32'd1);
    end
    master_valid = 1'b0; stall_en = 1'b0;
    repeat (4) cycle();
    chk("t3_count", 32'(xfer_count), 32'd10);
    chk("t3_npop", 32'(popped.size()), 32'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++)
      chk("t3_order", 32'(popped[i]), 32'hC0 + 32'(i));

    // 4: data change and valid drop while not ready
    do_reset(1);
    stall_en = 1'b1; master_valid = 1'b1; data = 8'h5A;
    repeat (2) cycle();
    data = 8'h5B;
    cycle();
    chk("t4_data_err", 32'(proto_err), 32'd1);
    stall_en = 1'b0; master_valid = 1'b0;
    repeat (3) cycle();
    chk("t4_sticky", 32'(proto_err), 32'd1);
    do_reset(1);
    stall_en = 1'b1; master_valid = 1'b1; data = 8'h77;
    repeat (2) cycle();
    chk("t4_clean_pending", 32'(proto_err), 32'd0);
    master_valid = 1'b0;
    cycle();
    chk("t4_drop_err", 32'(proto_err), 32'd1);
    stall_en = 1'b0;

    // 5: reset mid-fill
    do_reset(1);
    out_ready = 1'b0;
    send(8'h01); send(8'h02); send(8'h03);
    chk("t5_level3", 32'(level), 32'd3);
    rst_n = 1'b0;
    cycle();
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_count", 32'(xfer_count), 32'd0);
    chk("t5_ready_in_reset", 32'(slave_ready), 32'd0);
    rst_n = 1'b1;
    cycle();
    chk("t5_ready_after", 32'(slave_ready), 32'd1);

    // 6: transfer counter wrap
    do_reset(1);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) send(8'(i * 7));
    chk("t6_count15", 32'(xfer_count), 32'd15);
    send(8'hEE);
    chk("t6_wrap", 32'(xfer_count), 32'd0);

    // Random traffic with a protocol-respecting master
    do_reset(2);
    last_push = 0;
    for (int i = 0; i < 500; i++) begin
      stall_en  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (!master_valid || last_push) begin
        master_valid = ($urandom_range(0, 2) != 0);
        data = 8'($urandom);
      end
      cycle();
    end
    chk("rand_no_err", 32'(proto_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ready_valid_slave_fifo.md
Name: ready_valid_slave_fifo

Overview:
- Receiving end of the 8-bit ready/valid link: drives slave_ready and accepts data/master_valid from a ready_valid master.
- Buffers accepted bytes in a small FIFO and presents them to a local consumer through a second ready/valid port.
- Counts transfers and flags master-side protocol violations.
- Sits in RTL opposite a ready_valid master, or behind one in the testbench as a DUT-side sink.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  rising-edge clock; all logic is in this domain.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
- data  input  8  byte from master.
- master_valid  input  1  master has a byte on data.
- slave_ready  output  1  block can accept a byte this cycle.
- stall_en  input  1  forces slave_ready low; used for backpressure injection.
- out_data  output  8  head-of-FIFO byte.
- out_valid  output  1  out_data holds a valid byte.
- out_ready  input  1  consumer takes out_data this cycle.
- xfer_count  output  CNT_W  number of accepted input transfers, wraps.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- proto_err  output  1  sticky master protocol violation.

Behaviour:
- Reset, when rst_n is low at a clk edge:
  - level=0, out_valid=0, xfer_count=0, proto_err=0.
  - Read and write pointers go to 0.
  - out_data reads as 0; storage is not cleared.
  - Reset mid-transfer discards all buffered bytes.
  - While rst_n is low, slave_ready=0.
- slave_ready = rst_n_q && !stall_en && (level != DEPTH).
  - rst_n_q is a flop of rst_n, so ready rises one cycle after reset release.
  - There is no combinational path from out_ready or master_valid to slave_ready.
- push = master_valid && slave_ready.
  - On push, data is written at wr_ptr, wr_ptr increments mod DEPTH, and xfer_count increments.
  - xfer_count wraps from 2^CNT_W-1 to 0.
- pop = out_valid && out_ready.
  - On pop, rd_ptr increments mod DEPTH.
- out_valid = (level != 0); out_data = mem[rd_ptr], first-word fall-through.
- Latency: a byte pushed at edge N is visible on out_data/out_valid after edge N, so it can be popped in cycle N+1. Minimum latency is 1 cycle.
- level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Boundaries:
  - Full (level=DEPTH): slave_ready=0, so no push. A pop frees a slot and ready returns the next cycle, not the same cycle.
  - Empty (level=0): out_valid=0; out_ready is ignored.
  - Push and pop at level=1: out_valid stays 1 and out_data advances to the new byte.
  - Pointer wrap from DEPTH-1 to 0 is seamless.
  - stall_en only blocks input; draining continues.
- Protocol monitor: register prev_pending = master_valid && !slave_ready, plus prev_data.
  - When prev_pending is set, proto_err is set if master_valid is now 0, or if data != prev_data.
  - proto_err is sticky until reset.
  - The monitor never alters the data path.

Test Plan:
1. Reset, then drive master_valid=1 with data 0x11, 0x22, 0x33 back-to-back, out_ready=1. Required: slave_ready=1 from the 2nd cycle after reset release; out_data shows 0x11, 0x22, 0x33 one cycle after each accept; level stays ≤1; xfer_count=3; proto_err=0.
2. DEPTH=4, out_ready=0, push 0xA0..0xA4 continuously. Required: 4 accepts; slave_ready=0 at level=4; 0xA4 is held. Then pulse out_ready for 1 cycle: 0xA0 pops, slave_ready=1 the next cycle, and 0xA4 is accepted.
3. Stream 10 bytes with out_ready=1 and stall_en toggling every 2 cycles. Required: the output sequence is identical to the input with none lost or duplicated; xfer_count=10; the pointers wrap twice.
4. Hold master_valid=1 with data 0x5A while stall_en=1, then change data to 0x5B before ready. Required: proto_err=1 the next cycle and stays 1; a separate run that drops valid before ready also sets proto_err.
5. Fill to level=3, assert rst_n=0 for 1 cycle. Required: level=0, out_valid=0, xfer_count=0, slave_ready=0 during reset, slave_ready=1 one cycle after release.
6. Preload xfer_count by pushing 2^CNT_W-1 transfers (CNT_W=4 build: 15), then one more. Required: xfer_count wraps to 0.
